// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 32x32 unsigned shift-and-add multiplier
// borrowing the shared ALU adder; datapath passthrough when idle.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod_hi,
  output logic [31:0] prod_lo,
  output logic        dp_stall,
  input  logic [31:0] dp_a,
  input  logic [31:0] dp_b,
  input  logic [3:0]  dp_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctl,
  input  logic [31:0] alu_res
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0] CTL_ADD = 4'b0010;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [4:0]  cnt;
  logic        run;
  logic        carry;
  logic [31:0] nxt_hi;
  logic [31:0] nxt_lo;

  assign run = (state == S_RUN);

  // ALU owner mux: sequencer in RUN, datapath otherwise
  always_comb begin
    alu_a   = dp_a;
    alu_b   = dp_b;
    alu_ctl = dp_ctl;
    if (run) begin
      alu_a   = acc_hi;
      alu_b   = acc_lo[0] ? mcand : 32'd0;
      alu_ctl = CTL_ADD;
    end
  end

  // ALU has no carry out; a wrapped sum is smaller than an addend
  assign carry  = (alu_res < acc_hi);
  assign nxt_hi = {carry, alu_res[31:1]};
  assign nxt_lo = {alu_res[0], acc_lo[31:1]};

  // Sequencer FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      prod_hi  <= '0;
      prod_lo  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dp_stall <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand    <= op_a;
            acc_hi   <= '0;
            acc_lo   <= op_b;
            cnt      <= '0;
            state    <= S_RUN;
            busy     <= 1'b1;
            dp_stall <= 1'b1;
          end else begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            dp_stall <= 1'b0;
          end
        end
        S_RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            prod_hi  <= nxt_hi;
            prod_lo  <= nxt_lo;
            state    <= S_DONE;
            done     <= 1'b1;
            dp_stall <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          dp_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
